multi_ch_capture: RTL

MULTI_CH_CAPTURE -- requirements
Module: multi_ch_capture

---
 rtl/mch_capture_pkg.sv | 7 +
 rtl/ch_align_fifo.sv | 49 ++++
 rtl/multi_ch_capture.sv | 99 +++++++++
 3 files changed

// File: rtl/mch_capture_pkg.sv
// mch_capture_pkg: capture state encoding and default sizing for multi_ch_capture.
package mch_capture_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE_ST} cap_state_e;
    localparam int DEF_NUM_CH = 2;
    localparam int DEF_DATA_W = 14;
    localparam int DEF_DEPTH  = 8;
endpackage

// File: rtl/ch_align_fifo.sv
// ch_align_fifo: per-channel alignment FIFO with show-ahead read, flush and overflow pulse.
module ch_align_fifo
    import mch_capture_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              ovf
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] cnt_q, cnt_d;
    logic full, do_push, do_pop;
    always_comb begin
        empty    = cnt_q == '0;
        full     = cnt_q == (AW+1)'(DEPTH);
        do_pop   = pop && !empty;
        // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
        do_push  = push && (!full || do_pop);
        ovf      = push && full && !do_pop && !flush;
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(do_push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(do_pop);
        cnt_d    = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        dout     = mem[rd_ptr_q];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/multi_ch_capture.sv
// multi_ch_capture: aligns NUM_CH ADC streams into frames and captures CAP_LEN of them after a trigger.
// Optional MCH_DECIM_EN adds DECIM[7:0]: only every (DECIM+1)-th frame is forwarded during capture.
module multi_ch_capture
    import mch_capture_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     SYS_CLK,
    input  logic                     RESET,
    input  logic [NUM_CH*DATA_W-1:0] CH_D,
    input  logic [NUM_CH-1:0]        CH_VALID,
    input  logic                     ARM,
    input  logic                     TRIG,
    input  logic [15:0]              CAP_LEN,
`ifdef MCH_DECIM_EN
    input  logic [7:0]               DECIM,
`endif
    output logic [NUM_CH*DATA_W-1:0] OUT_DATA,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [NUM_CH-1:0]        OVF,
    output logic [15:0]              FRAME_CNT
);
    cap_state_e state_q, state_d;
    logic [NUM_CH*DATA_W-1:0] fifo_dout, out_data_q, out_data_d;
    logic [NUM_CH-1:0] empty, ovf_pulse, ovf_q, ovf_d;
    logic [15:0] frame_cnt_q, frame_cnt_d, len;
    logic out_valid_q, out_valid_d;
    logic frame_avail, accept, room, fwd, load, pop, flush;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        ch_align_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk(SYS_CLK), .rst(RESET), .flush(flush), .push(CH_VALID[k]), .pop(pop),
            .din(CH_D[k*DATA_W +: DATA_W]), .dout(fifo_dout[k*DATA_W +: DATA_W]),
            .empty(empty[k]), .ovf(ovf_pulse[k])
        );
    end

`ifdef MCH_DECIM_EN
    logic [7:0] decim_cnt_q, decim_cnt_d;
    always_comb begin
        fwd         = decim_cnt_q == 8'd0;
        decim_cnt_d = (state_q == ARMED && TRIG) ? 8'd0 :
                      (state_q == CAPTURE && pop) ? ((decim_cnt_q == DECIM) ? 8'd0 : decim_cnt_q + 8'd1) :
                      decim_cnt_q;
    end
    always_ff @(posedge SYS_CLK) begin
        if (RESET) decim_cnt_q <= '0;
        else decim_cnt_q <= decim_cnt_d;
    end
`else
    assign fwd = 1'b1;
`endif

    always_comb begin
        len         = (CAP_LEN == 16'd0) ? 16'd1 : CAP_LEN;
        frame_avail = ~|empty;
        accept      = out_valid_q && OUT_READY;
        // frames already delivered plus the one sitting in the output register
        room        = (17'(frame_cnt_q) + 17'(out_valid_q)) < 17'(len);
        load        = state_q == CAPTURE && !ARM && frame_avail && fwd && room && (!out_valid_q || OUT_READY);
        pop         = frame_avail && (state_q != CAPTURE || load || !fwd);
        flush       = ARM && state_q == CAPTURE;
        frame_cnt_d = ARM ? 16'd0 : frame_cnt_q + 16'(accept);
        out_valid_d = !ARM && (load || (out_valid_q && !OUT_READY));
        out_data_d  = load ? fifo_dout : out_data_q;
        ovf_d       = ARM ? '0 : (ovf_q | ovf_pulse);
        state_d     = ARM ? ARMED :
                      (state_q == ARMED && TRIG) ? CAPTURE :
                      (state_q == CAPTURE && frame_cnt_d == len) ? DONE_ST : state_q;
    end

    always_ff @(posedge SYS_CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_cnt_q <= '0;
            ovf_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    assign OUT_DATA  = out_data_q;
    assign OUT_VALID = out_valid_q;
    assign FRAME_CNT = frame_cnt_q;
    assign OVF       = ovf_q;
    assign BUSY      = state_q == ARMED || state_q == CAPTURE;
    assign DONE      = state_q == DONE_ST;
endmodule
